chip8_host_bridge: RTL and testbench

- Parametrised successor to the Chip-8 top-level host controller.
- Decodes Avalon-MM slave accesses from the ARM side into these resources: a register file (V0..VF, I, PC, SP), a hardware call stack, a keypad latch and a run-control state machine.
- Arbitrates one single-port program memory between host accesses and a two-byte instruction-fetch engine.
- Hands fetched instructions to the CPU core over a valid/ready handshake.

---
 rtl/chip8_host_bridge.sv | 252 +++++++++++++++++++++++++
 tb/tb_chip8_host_bridge.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chip8_host_bridge.sv
// Chip-8 host bridge: Avalon-MM access to registers, call stack, keypad latch and run
// control, plus a two-byte instruction fetch engine sharing one single-port program memory.
module chip8_host_bridge #(
  parameter int ADDR_W      = 18,
  parameter int MEM_AW      = 12,
  parameter int STACK_DEPTH = 16,
  parameter int PC_RESET    = 'h200
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              chipselect,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              waitrequest,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  input  logic [7:0]        mem_rdata,
  output logic [15:0]       instr,
  output logic [MEM_AW-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic [MEM_AW-1:0] cpu_next_pc,
  output logic              key_pressed,
  output logic [3:0]        key_code,
  output logic [1:0]        run_state
);
  localparam int OFF_W  = ADDR_W - 2;
  localparam int SIDX_W = $clog2(STACK_DEPTH);
  localparam int SP_W   = SIDX_W + 1;
  localparam logic [MEM_AW-1:0] PC_INIT = MEM_AW'(PC_RESET);
  localparam logic [SP_W-1:0]   SP_FULL = SP_W'(STACK_DEPTH);

  localparam logic [1:0] RS_RUN    = 2'd0;
  localparam logic [1:0] RS_PAUSED = 2'd1;
  localparam logic [1:0] RS_STEP   = 2'd3;

  localparam logic [1:0] F_IDLE = 2'd0;
  localparam logic [1:0] F_HI   = 2'd1;
  localparam logic [1:0] F_LO   = 2'd2;
  localparam logic [1:0] F_VAL  = 2'd3;

  localparam logic [OFF_W-1:0] R_I    = OFF_W'('h10);
  localparam logic [OFF_W-1:0] R_SP   = OFF_W'('h13);
  localparam logic [OFF_W-1:0] R_PC   = OFF_W'('h14);
  localparam logic [OFF_W-1:0] R_KEY  = OFF_W'('h15);
  localparam logic [OFF_W-1:0] R_RUN  = OFF_W'('h16);
  localparam logic [OFF_W-1:0] R_STAT = OFF_W'('h17);
  localparam logic [OFF_W-1:0] R_STK  = OFF_W'('h18);
  localparam logic [OFF_W-1:0] R_POP  = OFF_W'('h19);

  logic [7:0]        v_q [16];
  logic [7:0]        v_d [16];
  logic [15:0]       i_q, i_d;
  logic [MEM_AW-1:0] pc_q, pc_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic [MEM_AW-1:0] stack_q [STACK_DEPTH];
  logic              stack_err_q, stack_err_d;
  logic              key_pressed_q, key_pressed_d;
  logic [3:0]        key_code_q, key_code_d;
  logic [1:0]        run_q, run_d;
  logic [1:0]        fsm_q, fsm_d;
  logic [15:0]       instr_q, instr_d;
  logic              ivld_q, ivld_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_mem_q, rd_mem_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              push_en;

  logic              is_mem, is_pc, f_idle;
  logic              wr_req, rd_req, wr_stall, wr_fire, rd_fire;
  logic              host_claim, fetch_go;
  logic [OFF_W-1:0]  off;
  logic [SP_W-1:0]   sp_m1;
  logic [31:0]       reg_rdata;
  logic              unused_bits;

  assign unused_bits = ^{writedata[31:16], address[ADDR_W-1]};

  assign is_mem   = address[ADDR_W-2];
  assign off      = address[OFF_W-1:0];
  assign is_pc    = !is_mem && (off == R_PC);
  assign f_idle   = (fsm_q == F_IDLE);
  assign sp_m1    = sp_q - SP_W'(1);

  // A read spends one cycle with waitrequest high, then completes while the pending flag is set.
  assign wr_req   = chipselect && write && !read && !rd_pend_q;
  assign rd_req   = chipselect && read && !rd_pend_q;
  assign wr_stall = wr_req && !f_idle && (is_mem || is_pc);
  assign wr_fire  = wr_req && !wr_stall && !reset;
  assign rd_fire  = rd_req && (!is_mem || f_idle) && !reset;

  assign host_claim = (rd_req && is_mem) || (wr_req && (is_mem || is_pc));
  assign fetch_go   = f_idle && (run_q == RS_RUN || run_q == RS_STEP) && !host_claim;

  assign waitrequest = !reset && (rd_req || wr_stall);
  assign mem_we      = wr_fire && is_mem;
  assign mem_wdata   = writedata[7:0];
  assign readdata    = (rd_pend_q && rd_mem_q) ? {24'h0, mem_rdata} : rdata_q;

  assign instr       = instr_q;
  assign instr_valid = ivld_q;
  assign instr_pc    = pc_q;
  assign key_pressed = key_pressed_q;
  assign key_code    = key_code_q;
  assign run_state   = run_q;

  always_comb begin
    case (fsm_q)
      F_HI:    mem_addr = pc_q;
      F_LO:    mem_addr = pc_q + MEM_AW'(1);
      default: mem_addr = address[MEM_AW-1:0];
    endcase
  end

  always_comb begin
    reg_rdata = '0;
    if (off[OFF_W-1:4] == '0) begin
      reg_rdata = {24'h0, v_q[off[3:0]]};
    end else begin
      case (off)
        R_I:    reg_rdata = {16'h0, i_q};
        R_SP:   reg_rdata = 32'(sp_q);
        R_PC:   reg_rdata = 32'(pc_q);
        R_RUN:  reg_rdata = 32'(run_q);
        R_STAT: reg_rdata = {30'h0, !f_idle, stack_err_q};
        R_STK:  if (sp_q != '0) reg_rdata = 32'(stack_q[sp_m1[SIDX_W-1:0]]);
        default: ;
      endcase
    end
  end

  always_comb begin
    v_d           = v_q;
    i_d           = i_q;
    pc_d          = pc_q;
    sp_d          = sp_q;
    stack_err_d   = stack_err_q;
    key_pressed_d = key_pressed_q;
    key_code_d    = key_code_q;
    run_d         = run_q;
    fsm_d         = fsm_q;
    instr_d       = instr_q;
    ivld_d        = ivld_q;
    rd_pend_d     = rd_pend_q;
    rd_mem_d      = rd_mem_q;
    rdata_d       = rdata_q;
    push_en       = 1'b0;

    if (rd_pend_q) begin
      rd_pend_d = 1'b0;
      if (rd_mem_q) rdata_d = {24'h0, mem_rdata};
    end else if (rd_fire) begin
      rd_pend_d = 1'b1;
      rd_mem_d  = is_mem;
      if (!is_mem) rdata_d = reg_rdata;
    end

    // Once started, a fetch runs through accept regardless of later run_state changes.
    case (fsm_q)
      F_IDLE: if (fetch_go) fsm_d = F_HI;
      F_HI:   fsm_d = F_LO;
      F_LO: begin
        instr_d[15:8] = mem_rdata;
        fsm_d         = F_VAL;
      end
      default: begin
        if (!ivld_q) begin
          instr_d[7:0] = mem_rdata;
          ivld_d       = 1'b1;
        end else if (instr_ready) begin
          ivld_d = 1'b0;
          pc_d   = cpu_next_pc;
          fsm_d  = F_IDLE;
          if (run_q == RS_STEP) run_d = RS_PAUSED;
        end
      end
    endcase

    if (wr_fire && !is_mem) begin
      if (off[OFF_W-1:4] == '0) begin
        v_d[off[3:0]] = writedata[7:0];
      end else begin
        case (off)
          R_I:  i_d  = writedata[15:0];
          R_PC: pc_d = writedata[MEM_AW-1:0];
          R_KEY: begin
            key_pressed_d = writedata[4];
            key_code_d    = writedata[3:0];
          end
          R_RUN:  run_d       = writedata[1:0];
          R_STAT: stack_err_d = 1'b0;
          R_STK: begin
            if (sp_q == SP_FULL) begin
              stack_err_d = 1'b1;
            end else begin
              push_en = 1'b1;
              sp_d    = sp_q + SP_W'(1);
            end
          end
          R_POP: begin
            if (sp_q == '0) stack_err_d = 1'b1;
            else            sp_d        = sp_m1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 16; k++) v_q[k] <= '0;
      i_q           <= '0;
      pc_q          <= PC_INIT;
      sp_q          <= '0;
      stack_err_q   <= 1'b0;
      key_pressed_q <= 1'b0;
      key_code_q    <= '0;
      run_q         <= RS_PAUSED;
      fsm_q         <= F_IDLE;
      instr_q       <= '0;
      ivld_q        <= 1'b0;
      rd_pend_q     <= 1'b0;
      rd_mem_q      <= 1'b0;
      rdata_q       <= '0;
    end else begin
      v_q           <= v_d;
      i_q           <= i_d;
      pc_q          <= pc_d;
      sp_q          <= sp_d;
      stack_err_q   <= stack_err_d;
      key_pressed_q <= key_pressed_d;
      key_code_q    <= key_code_d;
      run_q         <= run_d;
      fsm_q         <= fsm_d;
      instr_q       <= instr_d;
      ivld_q        <= ivld_d;
      rd_pend_q     <= rd_pend_d;
      rd_mem_q      <= rd_mem_d;
      rdata_q       <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) stack_q[sp_q[SIDX_W-1:0]] <= writedata[MEM_AW-1:0];
  end

endmodule

// File: tb/tb_chip8_host_bridge.sv
// Bench for chip8_host_bridge: register table, directed fetch/stack/reset sequences and
// randomized host traffic checked against a behavioural model of the bridge.
module tb_chip8_host_bridge;
  logic        clk = 1'b0;
  logic        reset, chipselect, read, write;
  logic [17:0] address;
  logic [31:0] writedata, readdata;
  logic        waitrequest;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_we;
  logic [15:0] instr;
  logic [11:0] instr_pc, cpu_next_pc;
  logic        instr_valid, instr_ready;
  logic        key_pressed;
  logic [3:0]  key_code;
  logic [1:0]  run_state;

  int tests = 0;
  int fails = 0;

  logic [7:0] mem [4096];
  logic [7:0] mem_exp [int];
  int         waddr_q [$];

  chip8_host_bridge dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .read(read), .write(write),
    .address(address), .writedata(writedata), .readdata(readdata), .waitrequest(waitrequest),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .cpu_next_pc(cpu_next_pc), .key_pressed(key_pressed), .key_code(key_code),
    .run_state(run_state)
  );

  always #5 clk = ~clk;

  // Single-port program memory with one cycle of read latency.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic host_write(input logic [17:0] a, input logic [31:0] d);
    int n;
    n = 0;
    chipselect = 1'b1; write = 1'b1; read = 1'b0; address = a; writedata = d;
    #1;
    while (waitrequest && n < 200) begin @(negedge clk); #1; n++; end
    if (waitrequest) check("wr_timeout", 32'(n), 32'd0);
    @(posedge clk);
    if (a[16]) begin
      mem_exp[int'(a[11:0])] = d[7:0];
      waddr_q.push_back(int'(a[11:0]));
    end
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic host_read(input logic [17:0] a, output logic [31:0] d, output int waits);
    waits = 0;
    chipselect = 1'b1; read = 1'b1; write = 1'b0; address = a;
    #1;
    while (waitrequest && waits < 200) begin @(negedge clk); #1; waits++; end
    if (waitrequest) check("rd_timeout", 32'(waits), 32'd1);
    d = readdata;
    @(posedge clk);
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [17:0] a, input logic [31:0] exp);
    logic [31:0] d;
    int w;
    host_read(a, d, w);
    check(name, d, exp);
  endtask

  task automatic wait_valid();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (instr_valid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("instr_valid_wait", 32'(ok), 32'd1);
  endtask

  task automatic accept(input logic [11:0] n);
    instr_ready = 1'b1; cpu_next_pc = n;
    @(posedge clk);
    @(negedge clk);
    instr_ready = 1'b0;
  endtask

  typedef struct {
    logic        do_wr;
    logic [17:0] waddr;
    logic [31:0] wdata;
    logic [17:0] raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [12];

  logic [7:0]  v_m [16];
  logic [15:0] i_m;
  logic [11:0] stk_m [$];
  logic        err_m;

  initial begin
    logic [31:0] d;
    int          w, n, op, k;
    logic        held;
    logic [11:0] p, nx;
    logic [7:0]  hi, lo;

    tbl[0]  = '{1'b1, 18'h03, 32'hA5,    18'h03, 32'hA5};
    tbl[1]  = '{1'b1, 18'h00, 32'h1FF,   18'h00, 32'hFF};
    tbl[2]  = '{1'b1, 18'h0F, 32'h3C,    18'h0F, 32'h3C};
    tbl[3]  = '{1'b1, 18'h10, 32'h12345, 18'h10, 32'h2345};
    tbl[4]  = '{1'b0, 18'h00, 32'h0,     18'h13, 32'h0};
    tbl[5]  = '{1'b1, 18'h11, 32'hDEAD,  18'h11, 32'h0};
    tbl[6]  = '{1'b1, 18'h15, 32'h0,     18'h15, 32'h0};
    tbl[7]  = '{1'b0, 18'h00, 32'h0,     18'h18, 32'h0};
    tbl[8]  = '{1'b0, 18'h00, 32'h0,     18'h19, 32'h0};
    tbl[9]  = '{1'b0, 18'h00, 32'h0,     18'h03, 32'hA5};
    tbl[10] = '{1'b1, 18'h20, 32'h55,    18'h20, 32'h0};
    tbl[11] = '{1'b0, 18'h00, 32'h0,     18'h17, 32'h0};

    reset = 1'b1; chipselect = 1'b0; read = 1'b0; write = 1'b0;
    address = '0; writedata = '0; instr_ready = 1'b0; cpu_next_pc = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    check("rst_readdata", readdata, 32'h0);
    check("rst_waitrequest", 32'(waitrequest), 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'h0);
    check("rst_instr_valid", 32'(instr_valid), 32'h0);
    check("rst_instr", 32'(instr), 32'h0);
    check("rst_key", {27'h0, key_pressed, key_code}, 32'h0);
    check("rst_run_state", 32'(run_state), 32'h1);

    host_read(18'h14, d, w);
    check("pc_after_reset", d, 32'h200);
    check("pc_read_waits", 32'(w), 32'd1);
    rd_check("run_state_reg", 18'h16, 32'h1);

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].do_wr) host_write(tbl[i].waddr, tbl[i].wdata);
      rd_check($sformatf("tbl%0d", i), tbl[i].raddr, tbl[i].exp);
    end

    // LOAD, fill memory, single-step one instruction
    host_write(18'h16, 32'd2);
    host_write(18'h10200, 32'h12);
    host_write(18'h10201, 32'h34);
    host_read(18'h10201, d, w);
    check("mem_read_back", d, 32'h34);
    check("mem_read_waits", 32'(w), 32'd1);
    host_write(18'h16, 32'd3);
    wait_valid();
    check("step_instr", 32'(instr), 32'h1234);
    check("step_instr_pc", 32'(instr_pc), 32'h200);
    accept(12'h202);
    check("step_valid_drop", 32'(instr_valid), 32'h0);
    check("step_paused", 32'(run_state), 32'h1);
    rd_check("step_pc", 18'h14, 32'h202);

    // address wrap-around on the second fetch byte
    host_write(18'h14, 32'hFFF);
    host_write(18'h10FFF, 32'hAB);
    host_write(18'h10000, 32'hCD);
    host_write(18'h16, 32'd0);
    wait_valid();
    check("wrap_instr", 32'(instr), 32'hABCD);
    check("wrap_instr_pc", 32'(instr_pc), 32'hFFF);

    // host memory read stalls while an instruction waits for acceptance
    chipselect = 1'b1; read = 1'b1; address = 18'h10200;
    #1;
    held = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (!waitrequest) held = 1'b0;
      @(negedge clk); #1;
    end
    check("stall_held", 32'(held), 32'h1);
    check("stall_instr_stable", 32'(instr), 32'hABCD);
    instr_ready = 1'b1; cpu_next_pc = 12'h200;
    @(posedge clk);
    @(negedge clk);
    instr_ready = 1'b0;
    #1;
    n = 0;
    while (waitrequest && n < 20) begin @(negedge clk); #1; n++; end
    check("stall_release_waits", 32'(n), 32'd1);
    check("stall_read_data", readdata, 32'h12);
    @(posedge clk);
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;

    // pausing mid-fetch lets the in-flight instruction complete, then halts
    host_write(18'h16, 32'd1);
    wait_valid();
    check("pause_instr", 32'(instr), 32'h1234);
    accept(12'h300);
    repeat (8) @(negedge clk);
    check("pause_no_fetch", 32'(instr_valid), 32'h0);
    rd_check("pause_status", 18'h17, 32'h0);
    rd_check("pause_pc", 18'h14, 32'h300);

    // stack overflow / underflow
    for (int i = 1; i <= 16; i++) host_write(18'h18, 32'(i));
    rd_check("stk_sp_full", 18'h13, 32'd16);
    host_write(18'h18, 32'd17);
    rd_check("stk_sp_after_ovf", 18'h13, 32'd16);
    rd_check("stk_err_ovf", 18'h17, 32'h1);
    rd_check("stk_top_full", 18'h18, 32'd16);
    for (int i = 0; i < 8; i++) host_write(18'h19, 32'd0);
    rd_check("stk_top_half", 18'h18, 32'd8);
    for (int i = 0; i < 8; i++) host_write(18'h19, 32'd0);
    rd_check("stk_sp_empty", 18'h13, 32'd0);
    rd_check("stk_top_empty", 18'h18, 32'd0);
    host_write(18'h17, 32'd0);
    host_write(18'h19, 32'd0);
    rd_check("stk_sp_underflow", 18'h13, 32'd0);
    rd_check("stk_err_unf", 18'h17, 32'h1);
    host_write(18'h17, 32'hFFFF);
    rd_check("stk_err_clear", 18'h17, 32'h0);

    // keypad latch
    host_write(18'h15, 32'h1A);
    check("key_pressed", 32'(key_pressed), 32'h1);
    check("key_code", 32'(key_code), 32'hA);
    rd_check("key_reads_zero", 18'h15, 32'h0);

    // reset in the middle of a fetch
    host_write(18'h14, 32'h200);
    rd_check("pre_reset_pc", 18'h14, 32'h200);
    host_write(18'h16, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_instr_valid", 32'(instr_valid), 32'h0);
    check("midrst_instr", 32'(instr), 32'h0);
    check("midrst_readdata", readdata, 32'h0);
    check("midrst_waitrequest", 32'(waitrequest), 32'h0);
    check("midrst_mem_we", 32'(mem_we), 32'h0);
    check("midrst_key", {27'h0, key_pressed, key_code}, 32'h0);
    check("midrst_run_state", 32'(run_state), 32'h1);
    reset = 1'b0;
    rd_check("midrst_pc", 18'h14, 32'h200);
    rd_check("midrst_status", 18'h17, 32'h0);

    // randomized traffic against the reference model
    for (int i = 0; i < 16; i++) v_m[i] = 8'h0;
    i_m = 16'h0; stk_m.delete(); err_m = 1'b0;
    for (int it = 0; it < 160; it++) begin
      op = $urandom_range(0, 9);
      case (op)
        0: begin
          k = $urandom_range(0, 15); d = $urandom;
          host_write(18'(k), d);
          v_m[k] = d[7:0];
        end
        1: begin
          k = $urandom_range(0, 15);
          rd_check($sformatf("rnd_v%0d", k), 18'(k), 32'(v_m[k]));
        end
        2: begin
          d = $urandom;
          host_write(18'h10, d);
          i_m = d[15:0];
        end
        3: begin
          case ($urandom_range(0, 3))
            0: rd_check("rnd_i", 18'h10, 32'(i_m));
            1: rd_check("rnd_sp", 18'h13, 32'(stk_m.size()));
            2: rd_check("rnd_top", 18'h18, (stk_m.size() > 0) ? 32'(stk_m[$]) : 32'h0);
            default: rd_check("rnd_status", 18'h17, 32'(err_m));
          endcase
        end
        4: begin
          if ($urandom_range(0, 1) == 1) begin
            d = $urandom;
            host_write(18'h18, d);
            if (stk_m.size() < 16) stk_m.push_back(d[11:0]);
            else err_m = 1'b1;
          end else begin
            host_write(18'h19, 32'd0);
            if (stk_m.size() > 0) void'(stk_m.pop_back());
            else err_m = 1'b1;
          end
        end
        5: host_write(18'h10000 + 18'($urandom_range(0, 4095)), $urandom);
        6: begin
          if (waddr_q.size() > 0) begin
            k = waddr_q[$urandom_range(0, waddr_q.size() - 1)];
            rd_check("rnd_mem", 18'h10000 + 18'(k), 32'(mem_exp[k]));
          end
        end
        7: begin
          p = 12'($urandom); nx = 12'($urandom); hi = 8'($urandom); lo = 8'($urandom);
          host_write(18'h14, 32'(p));
          host_write(18'h10000 + 18'(p), 32'(hi));
          host_write(18'h10000 + 18'(p + 12'd1), 32'(lo));
          host_write(18'h16, 32'd3);
          wait_valid();
          check("rnd_fetch_instr", 32'(instr), {16'h0, hi, lo});
          check("rnd_fetch_pc", 32'(instr_pc), 32'(p));
          accept(nx);
          check("rnd_fetch_paused", 32'(run_state), 32'h1);
          rd_check("rnd_fetch_next_pc", 18'h14, 32'(nx));
        end
        8: begin
          host_write(18'h17, $urandom);
          err_m = 1'b0;
        end
        default: begin
          d = $urandom;
          host_write(18'h15, d);
          check("rnd_key", {27'h0, key_pressed, key_code}, {27'h0, d[4:0]});
        end
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
